gmii_tx_arbiter: RTL
====================

Name: gmii_tx_arbiter

Overview:
- Shares the single GMII transmit interface of the RGMII bridge between two frame sources, e.g. UDP/IP TX (port 0) and ARP TX (port 1).
- Grants whole frames using round-robin arbitration.
- Enforces a minimum inter-frame gap and aborts frames on underrun, oversize or link loss by asserting gmii_tx_er.
- Sits directly upstream of the bridge's gmii_txd / gmii_tx_en / gmii_tx_er inputs, in the gmii_tx_clk domain.

Parameters:
- IFG_CYCLES, 12, number of gmii_tx_en-low cycles guaranteed between frames on the wire; legal range 2..255.
- MAX_FRAME_BYTES, 1530, maximum bytes per frame including preamble/SFD; the frame is aborted if this is exceeded.
- CNT_W, 11, width of the byte counter; must satisfy 2^CNT_W > MAX_FRAME_BYTES.

Ports:
- gmii_tx_clk  in  1  GMII transmit clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- link_up  in  1  PHY link status. No grants are issued while it is 0.
- req0 / req1  in  1  frame request, held high until the matching gnt is seen.
- gnt0 / gnt1  out  1  registered grant, high for the entire frame of that port.
- txd0 / txd1  in  8  frame byte from the port.
- tx_valid0 / tx_valid1  in  1  byte valid; sampled only while the port's gnt is high.
- tx_last0 / tx_last1  in  1  marks the final byte of the frame; qualified by tx_valid.
- gmii_txd  out  8  to the bridge.
- gmii_tx_en  out  1  to the bridge.
- gmii_tx_er  out  1  to the bridge.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes normally.
- err_underrun  out  1  one-cycle pulse.
- err_oversize  out  1  one-cycle pulse.
- err_link  out  1  one-cycle pulse.

Behaviour:

Reset:
- All outputs go to 0 and the state goes to IDLE.
- The round-robin pointer last_port resets to 1, so port 0 wins the first tie.
- Reset asserted mid-frame: gnt, gmii_tx_en and gmii_tx_er drop the cycle after reset is sampled. No error pulse is generated.

GMII outputs:
- Registered, one cycle of latency from the sampled port inputs.
- In IDLE and IFG: gmii_txd = 0, gmii_tx_en = 0, gmii_tx_er = 0.

State IDLE:
- If link_up = 1 and any req is high, grant a port:
  - If only one req is high, grant that port.
  - If both are high, grant the port that is not last_port.
- On a grant: set gnt for the winner, update last_port, clear the byte counter and the started flag, go to SEND.
- If link_up = 0, stay in IDLE.

State SEND (port N):
- Each cycle, gmii_txd <= txdN and gmii_tx_en <= tx_validN.
- Waiting for the first byte: before the first tx_validN, wait indefinitely. Low-valid cycles in this phase are not errors.
- First valid byte sets started.
- Counter: increments on each valid byte and saturates.
- Normal end: tx_validN & tx_lastN → gnt drops next cycle, frame_done pulses, go to IFG.
- Underrun: started & !tx_validN → go to ABORT with err_underrun.
- Oversize: a valid byte arriving when the count already equals MAX_FRAME_BYTES → that byte is not forwarded; go to ABORT with err_oversize.
- Link loss: link_up = 0 → go to ABORT with err_link. This takes priority over the underrun and oversize checks in the same cycle.
- A link loss before started still aborts, so a tx_er cycle is emitted.
- gnt drops on entering ABORT.

State ABORT:
- Exactly one cycle: gmii_tx_en = 1, gmii_tx_er = 1, gmii_txd = 0.
- Then go to IFG.

State IFG:
- Held for IFG_CYCLES-1 cycles, then go to IDLE.
- Combined with the one-cycle arbitration in IDLE, this yields exactly IFG_CYCLES low gmii_tx_en cycles on back-to-back frames. This assumes the requester asserts valid in the first gnt cycle.
- Requests arriving during IFG are held and serviced in IDLE.

Port rules:
- A requester may assert tx_valid combinationally in the same cycle its gnt is first seen high.
- tx_last without tx_valid is ignored.
- The non-granted port's inputs are ignored.
- The frame boundary is defined solely by tx_last; req may drop after gnt.

Error and status pulses:
- Each of frame_done, err_underrun, err_oversize and err_link is a single-cycle pulse, registered, coincident with the cycle the state leaves SEND.
- No two of these pulses are asserted in the same cycle.

Test Plan:
1. Single frame, no contention:
   - Stimulus: link_up = 1; req0 with a 64-byte frame of values 0x00..0x3F, valid every cycle.
   - Required response: gmii_tx_en high for exactly 64 cycles, gmii_txd = 0x00..0x3F in order, one cycle behind the input; one frame_done pulse; gnt0 high 64 cycles; gnt1 never high.
2. Round-robin and IFG under contention:
   - Stimulus: req0 and req1 both held high, each sending 3 frames of 60 bytes.
   - Required response: grant order 0,1,0,1,0,1; exactly 12 gmii_tx_en-low cycles between consecutive frames; 6 frame_done pulses.
3. Underrun:
   - Stimulus: port 1 frame; tx_valid1 dropped after byte 10, with no tx_last.
   - Required response: 10 bytes on the wire, then one cycle with gmii_tx_en = 1, gmii_tx_er = 1, gmii_txd = 0; err_underrun pulses once; gnt1 drops; next grant no earlier than 12 low cycles later.
4. Oversize:
   - Stimulus: MAX_FRAME_BYTES = 100; port 0 streams 150 bytes.
   - Required response: exactly 100 bytes forwarded, then the tx_er cycle; err_oversize pulses once; no frame_done.
5. Link loss:
   - Stimulus: link_up = 0 while a frame is at byte 20; req0 and req1 both held with link_up = 0 for 50 cycles.
   - Required response: tx_er cycle immediately after byte 20; err_link pulses once; then no gnt for the 50 cycles; normal arbitration resumes when link_up returns to 1.
6. Reset mid-frame and pre-start wait:
   - Stimulus: assert reset at byte 30. In a separate run, delay the first tx_valid by 40 cycles after gnt.
   - Required response, reset run: all outputs 0 on the next cycle, no error pulses, and port 0 is granted first after reset when both ports request.
   - Required response, delayed-start run: no error; the frame is sent intact once valid asserts.

Source files
------------

// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter
//   Shares one GMII transmit interface between two frame sources.
//   Whole frames are granted round-robin. A minimum inter-frame gap is enforced.
//   A frame is aborted with a one-cycle gmii_tx_er marker on underrun, oversize
//   or link loss.
//
// Ports (all in the gmii_tx_clk domain):
//   gmii_tx_clk, reset        clock, synchronous active-high reset
//   link_up                   PHY link status; no grants while low
//   req0/1, gnt0/1            frame request / registered whole-frame grant
//   txd0/1, tx_valid0/1,      per-port byte stream, sampled only while granted
//   tx_last0/1
//   gmii_txd/tx_en/tx_er      registered GMII outputs to the bridge
//   busy                      high whenever the arbiter is not IDLE
//   frame_done, err_underrun, one-cycle registered status pulses, issued as
//   err_oversize, err_link    SEND is left
module gmii_tx_arbiter #(
  parameter int IFG_CYCLES      = 12,
  parameter int MAX_FRAME_BYTES = 1530,
  parameter int CNT_W           = 11
) (
  input  logic       gmii_tx_clk,
  input  logic       reset,
  input  logic       link_up,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic [7:0] txd0,
  input  logic [7:0] txd1,
  input  logic       tx_valid0,
  input  logic       tx_valid1,
  input  logic       tx_last0,
  input  logic       tx_last1,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       busy,
  output logic       frame_done,
  output logic       err_underrun,
  output logic       err_oversize,
  output logic       err_link
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ABORT,
    IFG
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_FRAME_BYTES);
  // IFG state lasts IFG_CYCLES-1 cycles; the IDLE arbitration cycle is the last gap cycle.
  localparam logic [7:0]       IFG_LAST = 8'(IFG_CYCLES - 2);

  state_t           state_q, state_d;
  logic             last_port_q, last_port_d;
  logic             port_q, port_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             started_q, started_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       ifg_cnt_q, ifg_cnt_d;
  logic [7:0]       txd_q, txd_d;
  logic             en_q, en_d;
  logic             er_q, er_d;
  logic             done_q, done_d;
  logic             unr_q, unr_d;
  logic             ovs_q, ovs_d;
  logic             lnk_q, lnk_d;

  logic       win1;
  logic [7:0] sel_txd;
  logic       sel_valid;
  logic       sel_last;

  assign sel_txd   = port_q ? txd1      : txd0;
  assign sel_valid = port_q ? tx_valid1 : tx_valid0;
  assign sel_last  = port_q ? tx_last1  : tx_last0;

  always_comb begin
    state_d     = state_q;
    last_port_d = last_port_q;
    port_d      = port_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    started_d   = started_q;
    cnt_d       = cnt_q;
    ifg_cnt_d   = ifg_cnt_q;
    txd_d       = '0;
    en_d        = 1'b0;
    er_d        = 1'b0;
    done_d      = 1'b0;
    unr_d       = 1'b0;
    ovs_d       = 1'b0;
    lnk_d       = 1'b0;
    win1        = 1'b0;

    case (state_q)
      IDLE: begin
        if (link_up && (req0 || req1)) begin
          // On a tie the port that did not win last time goes first.
          win1        = req1 && (!req0 || !last_port_q);
          gnt0_d      = !win1;
          gnt1_d      = win1;
          last_port_d = win1;
          port_d      = win1;
          cnt_d       = '0;
          started_d   = 1'b0;
          state_d     = SEND;
        end
      end

      SEND: begin
        txd_d = sel_txd;
        en_d  = sel_valid;
        // The abort marker replaces whatever byte would have gone out this cycle.
        if (!link_up || (sel_valid && cnt_q == MAX_CNT) || (started_q && !sel_valid)) begin
          state_d = ABORT;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          txd_d   = '0;
          en_d    = 1'b1;
          er_d    = 1'b1;
          if (!link_up) begin
            lnk_d = 1'b1;
          end else if (sel_valid) begin
            ovs_d = 1'b1;
          end else begin
            unr_d = 1'b1;
          end
        end else if (sel_valid) begin
          started_d = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (sel_last) begin
            done_d    = 1'b1;
            gnt0_d    = 1'b0;
            gnt1_d    = 1'b0;
            ifg_cnt_d = '0;
            state_d   = IFG;
          end
        end
      end

      ABORT: begin
        ifg_cnt_d = '0;
        state_d   = IFG;
      end

      IFG: begin
        if (ifg_cnt_q == IFG_LAST) begin
          state_d = IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_port_q <= 1'b1;
      port_q      <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      started_q   <= 1'b0;
      cnt_q       <= '0;
      ifg_cnt_q   <= '0;
      txd_q       <= '0;
      en_q        <= 1'b0;
      er_q        <= 1'b0;
      done_q      <= 1'b0;
      unr_q       <= 1'b0;
      ovs_q       <= 1'b0;
      lnk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_port_q <= last_port_d;
      port_q      <= port_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      started_q   <= started_d;
      cnt_q       <= cnt_d;
      ifg_cnt_q   <= ifg_cnt_d;
      txd_q       <= txd_d;
      en_q        <= en_d;
      er_q        <= er_d;
      done_q      <= done_d;
      unr_q       <= unr_d;
      ovs_q       <= ovs_d;
      lnk_q       <= lnk_d;
    end
  end

  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign gmii_txd     = txd_q;
  assign gmii_tx_en   = en_q;
  assign gmii_tx_er   = er_q;
  assign busy         = (state_q != IDLE);
  assign frame_done   = done_q;
  assign err_underrun = unr_q;
  assign err_oversize = ovs_q;
  assign err_link     = lnk_q;

endmodule
